// File: rtl/usb_fx2_fifo_drain.sv
// Drains the merged channel-data FIFO into the Cypress FX2 slave FIFO (sync write, 16-bit).
// Tracks packet fill and commits short packets with PKTEND on idle timeout or acquisition stop.
module usb_fx2_fifo_drain #(
  parameter int         PKT_WORDS = 256,
  parameter int         TIMEOUT   = 1024,
  parameter logic [1:0] EP_ADDR   = 2'b10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst_all_fifo,
  input  logic        enable,
  input  logic [15:0] fifo_q,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  input  logic        fx2_full_n,
  output logic [15:0] fx2_fd,
  output logic        fx2_slwr_n,
  output logic        fx2_pktend_n,
  output logic [1:0]  fx2_fifoadr,
  output logic [31:0] words_sent
);

  localparam int PW = $clog2(PKT_WORDS);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_WORDS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LATCH, S_WR, S_PKTEND} state_t;

  state_t        state_q, state_d;
  logic          rdreq_q, rdreq_d;
  logic [15:0]   fd_q, fd_d;
  logic          slwr_n_q, slwr_n_d;
  logic          pktend_n_q, pktend_n_d;
  logic [31:0]   words_q, words_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          cap_q, cap_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rdreq_q    <= 1'b0;
      fd_q       <= 16'h0000;
      slwr_n_q   <= 1'b1;
      pktend_n_q <= 1'b1;
      words_q    <= 32'd0;
      pkt_q      <= '0;
      idle_q     <= '0;
      cap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdreq_q    <= rdreq_d;
      fd_q       <= fd_d;
      slwr_n_q   <= slwr_n_d;
      pktend_n_q <= pktend_n_d;
      words_q    <= words_d;
      pkt_q      <= pkt_d;
      idle_q     <= idle_d;
      cap_q      <= cap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rdreq_d    = 1'b0;
    fd_d       = fd_q;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;
    words_d    = words_q;
    pkt_d      = pkt_q;
    idle_d     = idle_q;
    cap_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty && fx2_full_n) begin
          rdreq_d = 1'b1;
          idle_d  = '0;
          state_d = S_RD;
        end else if (pkt_q != '0 && (!enable || idle_q == IDLE_LAST)) begin
          pktend_n_d = 1'b0;
          state_d    = S_PKTEND;
        end else if (pkt_q != '0) begin
          if (idle_q != IDLE_LAST) idle_d = idle_q + 1'b1;
        end else begin
          idle_d = '0;
        end
      end
      S_RD: state_d = S_LATCH;
      S_LATCH: begin
        // Capture only once so a long full_n stall cannot pick up a changed fifo_q.
        cap_d = 1'b1;
        if (!cap_q) fd_d = fifo_q;
        if (fx2_full_n) begin
          slwr_n_d = 1'b0;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        words_d = words_q + 32'd1;
        pkt_d   = (pkt_q == PKT_LAST) ? '0 : pkt_q + 1'b1;
        state_d = S_IDLE;
      end
      S_PKTEND: begin
        pkt_d   = '0;
        idle_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort drops any in-flight word without committing a packet.
    if (rst_all_fifo) begin
      state_d    = S_IDLE;
      rdreq_d    = 1'b0;
      slwr_n_d   = 1'b1;
      pktend_n_d = 1'b1;
      words_d    = 32'd0;
      pkt_d      = '0;
      idle_d     = '0;
      cap_d      = 1'b0;
    end
  end

  assign fifo_rdreq   = rdreq_q;
  assign fx2_fd       = fd_q;
  assign fx2_slwr_n   = slwr_n_q;
  assign fx2_pktend_n = pktend_n_q;
  assign fx2_fifoadr  = EP_ADDR;
  assign words_sent   = words_q;

endmodule

// File: tb/tb_usb_fx2_fifo_drain.sv
// Randomized scenario bench for usb_fx2_fifo_drain: FIFO model feeds words, a monitor logs FX2 writes.
module tb_usb_fx2_fifo_drain;
  localparam int PKT = 256;
  localparam int TO  = 64;

  logic        clk = 1'b0, reset_n = 1'b0, rst_all_fifo = 1'b0, enable = 1'b0, fx2_full_n = 1'b1;
  logic        fifo_empty, fifo_rdreq, slwr_n, pktend_n;
  logic [15:0] fifo_q = 16'h0, fx2_fd;
  logic [1:0]  fifoadr;
  logic [31:0] words_sent;

  always #5 clk = ~clk;

  usb_fx2_fifo_drain #(.PKT_WORDS(PKT), .TIMEOUT(TO), .EP_ADDR(2'b10)) dut (
    .clk(clk), .reset_n(reset_n), .rst_all_fifo(rst_all_fifo), .enable(enable),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .fx2_full_n(fx2_full_n), .fx2_fd(fx2_fd), .fx2_slwr_n(slwr_n),
    .fx2_pktend_n(pktend_n), .fx2_fifoadr(fifoadr), .words_sent(words_sent)
  );

  int checks = 0, errors = 0;

  // Data FIFO model: normal mode, q valid the cycle after rdreq. wp owned by tasks, rp by model.
  logic [15:0] mem [0:1023];
  int wp = 0, rp = 0, rd_empty = 0;
  assign fifo_empty = (rp == wp);
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      if (rp != wp) begin
        fifo_q <= mem[rp % 1024];
        rp     <= rp + 1;
      end else rd_empty <= rd_empty + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs every FX2 write and pulse, sampled on the falling edge.
  logic [15:0] wlog [0:2047];
  int wcyc [0:2047];
  int n_wr = 0, n_rd = 0, n_pe = 0, pe_cyc = 0, wide_err = 0, ovl = 0;
  logic prev_sl = 1'b0, prev_pe = 1'b0, prev_rd = 1'b0;
  always @(negedge clk) begin
    if (!slwr_n) begin
      wlog[n_wr % 2048] <= fx2_fd;
      wcyc[n_wr % 2048] <= cyc;
      n_wr <= n_wr + 1;
    end
    if (!pktend_n) begin
      n_pe   <= n_pe + 1;
      pe_cyc <= cyc;
    end
    if (fifo_rdreq) n_rd <= n_rd + 1;
    if (!slwr_n && !pktend_n) ovl <= ovl + 1;
    if ((!slwr_n && prev_sl) || (!pktend_n && prev_pe) || (fifo_rdreq && prev_rd))
      wide_err <= wide_err + 1;
    prev_sl <= !slwr_n;
    prev_pe <= !pktend_n;
    prev_rd <= fifo_rdreq;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wp % 1024] = w;
    wp = wp + 1;
  endtask

  task automatic wait_wr(input int target, input int bound, input string name);
    int k = 0;
    while (n_wr < target && k < bound) begin tick(1); k++; end
    checks++;
    if (n_wr < target) begin
      errors++;
      $display("FAIL %s_timeout writes=%0d want=%0d", name, n_wr, target);
    end
  endtask

  task automatic wait_rdreq(input string name);
    int k = 0;
    while (!fifo_rdreq && k < 40) begin tick(1); k++; end
    checks++;
    if (!fifo_rdreq) begin errors++; $display("FAIL %s_rdreq_timeout got=0 want=1", name); end
  endtask

  task automatic do_reset;
    reset_n = 1'b0; enable = 1'b0; fx2_full_n = 1'b1; rst_all_fifo = 1'b0;
    tick(2);
    wp = rp;
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(1);
    checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got=%b want=0", fifo_rdreq); end
    checks++; if (fx2_fd !== 16'h0) begin errors++; $display("FAIL reset_fd got=%h want=0000", fx2_fd); end
    checks++; if (slwr_n !== 1'b1) begin errors++; $display("FAIL reset_slwr got=%b want=1", slwr_n); end
    checks++; if (pktend_n !== 1'b1) begin errors++; $display("FAIL reset_pktend got=%b want=1", pktend_n); end
    checks++; if (fifoadr !== 2'b10) begin errors++; $display("FAIL reset_fifoadr got=%b want=10", fifoadr); end
    checks++; if (words_sent !== 32'd0) begin errors++; $display("FAIL reset_words got=%0d want=0", words_sent); end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic;
    logic [15:0] exp [3];
    int base, rd0, pe0, k;
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333;
    do_reset;
    base = n_wr; rd0 = n_rd; pe0 = n_pe;
    for (int i = 0; i < 3; i++) push(exp[i]);
    enable = 1'b1;
    wait_wr(base + 3, 40, "basic");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wlog[base + i] !== exp[i]) begin errors++; $display("FAIL basic_data%0d got=%h want=%h", i, wlog[base + i], exp[i]); end
    end
    checks++;
    if (wcyc[base + 1] - wcyc[base] != 4 || wcyc[base + 2] - wcyc[base + 1] != 4) begin
      errors++; $display("FAIL basic_spacing got=%0d,%0d want=4,4", wcyc[base + 1] - wcyc[base], wcyc[base + 2] - wcyc[base + 1]);
    end
    tick(1);
    checks++; if (words_sent !== 32'd3) begin errors++; $display("FAIL basic_words got=%0d want=3", words_sent); end
    checks++; if (n_rd - rd0 != 3) begin errors++; $display("FAIL basic_rdreq got=%0d want=3", n_rd - rd0); end
    k = 0;
    while (n_pe == pe0 && k < TO + 20) begin tick(1); k++; end
    checks++;
    if (n_pe == pe0 || pe_cyc - wcyc[base + 2] != TO + 1) begin
      errors++; $display("FAIL basic_timeout_pktend got_pulses=%0d delay=%0d want_delay=%0d", n_pe - pe0, pe_cyc - wcyc[base + 2], TO + 1);
    end
    tick(10);
    checks++; if (n_pe - pe0 != 1) begin errors++; $display("FAIL basic_pktend_count got=%0d want=1", n_pe - pe0); end
    enable = 1'b0;
  endtask

  task automatic test_full_packet;
    logic [15:0] fp [PKT];
    int base, rd0, pe0, bad;
    do_reset;
    base = n_wr; rd0 = n_rd; pe0 = n_pe; bad = 0;
    for (int i = 0; i < PKT; i++) begin fp[i] = 16'($urandom_range(0, 65535)); push(fp[i]); end
    enable = 1'b1;
    wait_wr(base + PKT, PKT * 4 + 50, "full");
    tick(TO + 20);
    for (int i = 0; i < PKT; i++) if (wlog[base + i] !== fp[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL full_data bad_words=%0d want=0", bad); end
    checks++; if (words_sent !== 32'(PKT)) begin errors++; $display("FAIL full_words got=%0d want=%0d", words_sent, PKT); end
    checks++; if (n_rd - rd0 != PKT) begin errors++; $display("FAIL full_rdreq got=%0d want=%0d", n_rd - rd0, PKT); end
    checks++; if (n_pe != pe0) begin errors++; $display("FAIL full_no_pktend got=%0d want=0", n_pe - pe0); end
    enable = 1'b0;
    tick(5);
    checks++; if (n_pe != pe0) begin errors++; $display("FAIL full_stop_pktend got=%0d want=0", n_pe - pe0); end
  endtask

  task automatic test_backpressure;
    int base, rd0, pe0, st_bad, fd_bad;
    do_reset;
    base = n_wr; rd0 = n_rd; pe0 = n_pe; st_bad = 0; fd_bad = 0;
    push(16'hABCD); push(16'h1234);
    enable = 1'b1;
    wait_rdreq("bp");
    fx2_full_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (slwr_n !== 1'b1) st_bad++;
      if (i >= 1 && fx2_fd !== 16'hABCD) fd_bad++;
    end
    checks++; if (st_bad != 0) begin errors++; $display("FAIL bp_slwr_held got_low=%0d want=0", st_bad); end
    checks++; if (fd_bad != 0) begin errors++; $display("FAIL bp_fd_held got_bad=%0d want=0", fd_bad); end
    checks++; if (n_rd - rd0 != 1) begin errors++; $display("FAIL bp_no_extra_rdreq got=%0d want=1", n_rd - rd0); end
    fx2_full_n = 1'b1;
    tick(1);
    checks++;
    if (slwr_n !== 1'b0 || fx2_fd !== 16'hABCD) begin
      errors++; $display("FAIL bp_resume got slwr=%b fd=%h want slwr=0 fd=abcd", slwr_n, fx2_fd);
    end
    wait_wr(base + 2, 40, "bp");
    checks++; if (wlog[base + 1] !== 16'h1234) begin errors++; $display("FAIL bp_second got=%h want=1234", wlog[base + 1]); end
    enable = 1'b0;
    tick(5);
    checks++; if (n_pe - pe0 != 1) begin errors++; $display("FAIL bp_flush got=%0d want=1", n_pe - pe0); end
  endtask

  task automatic test_stop_flush;
    int base, pe0, k;
    do_reset;
    base = n_wr; pe0 = n_pe;
    for (int i = 0; i < 5; i++) push(16'($urandom_range(0, 65535)));
    enable = 1'b1;
    wait_wr(base + 5, 60, "stop");
    enable = 1'b0;
    k = 0;
    while (n_pe == pe0 && k < 10) begin tick(1); k++; end
    checks++;
    if (n_pe == pe0 || pe_cyc - wcyc[base + 4] != 2) begin
      errors++; $display("FAIL stop_pktend_delay got_pulses=%0d delay=%0d want_delay=2", n_pe - pe0, pe_cyc - wcyc[base + 4]);
    end
    tick(20);
    checks++; if (n_pe - pe0 != 1) begin errors++; $display("FAIL stop_pktend_count got=%0d want=1", n_pe - pe0); end
    checks++; if (words_sent !== 32'd5) begin errors++; $display("FAIL stop_words got=%0d want=5", words_sent); end
    enable = 1'b1;
    tick(5);
    enable = 1'b0;
    tick(20);
    checks++; if (n_pe - pe0 != 1) begin errors++; $display("FAIL stop_empty_no_pktend got=%0d want=1", n_pe - pe0); end
  endtask

  task automatic test_abort;
    int base, pe0;
    do_reset;
    base = n_wr; pe0 = n_pe;
    push(16'h5A5A);
    enable = 1'b1;
    wait_rdreq("abort");
    tick(1);
    rst_all_fifo = 1'b1;
    tick(1);
    rst_all_fifo = 1'b0;
    wp = rp;
    tick(30);
    checks++; if (n_wr != base) begin errors++; $display("FAIL abort_no_write got=%0d want=0", n_wr - base); end
    checks++; if (words_sent !== 32'd0) begin errors++; $display("FAIL abort_words got=%0d want=0", words_sent); end
    checks++; if (n_pe != pe0) begin errors++; $display("FAIL abort_no_pktend got=%0d want=0", n_pe - pe0); end
    push(16'hC3C3);
    wait_wr(base + 1, 20, "abort_resume");
    tick(1);
    checks++;
    if (wlog[base] !== 16'hC3C3 || words_sent !== 32'd1) begin
      errors++; $display("FAIL abort_resume got data=%h words=%0d want data=c3c3 words=1", wlog[base], words_sent);
    end
    enable = 1'b0;
    tick(5);
  endtask

  task automatic test_random;
    logic [15:0] rw [64];
    int base, rd0, pe0, n, bad, k;
    for (int it = 0; it < 4; it++) begin
      do_reset;
      base = n_wr; rd0 = n_rd; pe0 = n_pe; bad = 0; k = 0;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin rw[i] = 16'($urandom_range(0, 65535)); push(rw[i]); end
      enable = 1'b1;
      while (n_wr < base + n && k < n * 20 + 100) begin
        fx2_full_n = ($urandom_range(0, 9) < 7);
        tick(1);
        k++;
      end
      fx2_full_n = 1'b1;
      checks++; if (n_wr != base + n) begin errors++; $display("FAIL rand%0d_writes got=%0d want=%0d", it, n_wr - base, n); end
      for (int i = 0; i < n; i++) if (wlog[base + i] !== rw[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_data bad=%0d want=0", it, bad); end
      enable = 1'b0;
      tick(10);
      checks++; if (words_sent !== 32'(n)) begin errors++; $display("FAIL rand%0d_words got=%0d want=%0d", it, words_sent, n); end
      checks++; if (n_rd - rd0 != n) begin errors++; $display("FAIL rand%0d_rdreq got=%0d want=%0d", it, n_rd - rd0, n); end
      checks++;
      if (n_pe - pe0 != ((n % PKT != 0) ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_pktend got=%0d want=%0d", it, n_pe - pe0, (n % PKT != 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_async_reset;
    int k = 0;
    do_reset;
    for (int i = 0; i < 3; i++) push(16'hF000 + 16'(i));
    enable = 1'b1;
    while (slwr_n !== 1'b0 && k < 40) begin tick(1); k++; end
    checks++; if (slwr_n !== 1'b0) begin errors++; $display("FAIL areset_wr_timeout got=%b want=0", slwr_n); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (slwr_n !== 1'b1 || fx2_fd !== 16'h0 || fifo_rdreq !== 1'b0 || pktend_n !== 1'b1) begin
      errors++; $display("FAIL areset_outputs got slwr=%b fd=%h rdreq=%b pktend=%b want 1 0000 0 1", slwr_n, fx2_fd, fifo_rdreq, pktend_n);
    end
    tick(1);
    enable = 1'b0;
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_packet;
    test_backpressure;
    test_stop_flush;
    test_abort;
    test_random;
    test_async_reset;
    checks++; if (wide_err != 0) begin errors++; $display("FAIL pulse_width got_wide=%0d want=0", wide_err); end
    checks++; if (ovl != 0) begin errors++; $display("FAIL slwr_pktend_overlap got=%0d want=0", ovl); end
    checks++; if (rd_empty != 0) begin errors++; $display("FAIL read_on_empty got=%0d want=0", rd_empty); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_fx2_fifo_drain.md
Name: usb_fx2_fifo_drain

Overview:
Reader on the far side of the merged channel-data FIFO. Fed by the per-channel FIFO controller, it pops 16-bit words from that FIFO and writes them into the Cypress FX2 slave FIFO (synchronous write mode, 16-bit bus) for upload to the host. It tracks packet fill and issues PKTEND to commit short packets on timeout or on acquisition stop. Clocked by the FX2 interface clock domain clk (same clock as the data FIFO read port).

Parameters:
PKT_WORDS, 256, words per FX2 packet (512-byte bulk); FX2 auto-commits at this count.
TIMEOUT, 1024, idle cycles with a partial packet before PKTEND is forced.
EP_ADDR, 2'b10, constant FIFOADR value (EP6 IN).

Ports:
clk  in  1  interface clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
rst_all_fifo  in  1  synchronous abort/clear, same pulse that clears the data FIFOs
enable  in  1  acquisition running; 0 = stop and flush the partial packet
fifo_q  in  16  data FIFO output (normal mode: valid the cycle after rdreq)
fifo_empty  in  1  data FIFO empty
fifo_rdreq  out  1  data FIFO read request, registered
fx2_full_n  in  1  FX2 FULL flag, active low (0 = FX2 FIFO full)
fx2_fd  out  16  FX2 data bus, registered
fx2_slwr_n  out  1  FX2 write strobe, active low, registered
fx2_pktend_n  out  1  FX2 packet end, active low, registered
fx2_fifoadr  out  2  FX2 FIFO address, constant EP_ADDR
words_sent  out  32  total words written to FX2 since reset/clear, wraps at 2^32

Behaviour:
- Reset (reset_n=0, async): state=IDLE, fifo_rdreq=0, fx2_fd=16'h0000, fx2_slwr_n=1, fx2_pktend_n=1, words_sent=0, pkt_cnt=0, idle_cnt=0. fx2_fifoadr=EP_ADDR always.
- FSM states: IDLE, RD, LATCH, WR, PKTEND.
- IDLE: if enable && !fifo_empty && fx2_full_n: fifo_rdreq<=1, idle_cnt<=0, go RD. Else if pkt_cnt!=0 and (!enable or idle_cnt==TIMEOUT-1): go PKTEND. Else if pkt_cnt!=0, idle_cnt++ (saturating); if pkt_cnt==0, idle_cnt<=0.
- RD (1 cycle): fifo_rdreq<=0, go LATCH. fifo_rdreq is high for exactly one cycle per word.
- LATCH: fx2_fd<=fifo_q. If fx2_full_n=1: fx2_slwr_n<=0, go WR. If fx2_full_n=0: stay in LATCH, fx2_fd holds the captured word, no further FIFO reads until full_n returns to 1.
- WR (slwr_n low exactly 1 cycle): fx2_slwr_n<=1, words_sent++, pkt_cnt<=(pkt_cnt==PKT_WORDS-1)?0:pkt_cnt+1, go IDLE.
- PKTEND: fx2_pktend_n low for exactly 1 cycle; pkt_cnt<=0, idle_cnt<=0, return to IDLE. Never asserted when pkt_cnt==0, so no zero-length packets are sent. Never asserted in the same cycle as slwr_n.
- Throughput: 4 clk per word when not stalled (IDLE->RD->LATCH->WR). fx2_fd stays stable from LATCH through the slwr_n low cycle.
- Full packet: reaching PKT_WORDS wraps pkt_cnt to 0 with no PKTEND (FX2 auto-commits).
- enable falling mid-word: the current word completes (RD/LATCH/WR), then IDLE flushes via PKTEND if pkt_cnt!=0.
- rst_all_fifo=1 (synchronous, highest priority after reset_n): state=IDLE, rdreq=0, slwr_n=1, pktend_n=1, pkt_cnt=0, idle_cnt=0, words_sent=0. Any word in flight is dropped; no PKTEND is issued.
- fifo_empty is sampled only in IDLE; the block never reads an empty FIFO.

Test Plan:
- Basic: enable=1, FIFO preloaded with 3 words 0x1111/0x2222/0x3333, full_n=1 -> 3 rdreq pulses, 3 slwr_n pulses 4 clk apart, fd matches in order, words_sent=3; after TIMEOUT idle cycles, one pktend_n pulse.
- Full packet: 256 words streamed -> 256 slwr_n pulses, no pktend_n, pkt_cnt=0, words_sent=256.
- Backpressure: full_n=0 while in LATCH for 10 cycles -> slwr_n stays 1, fd held, no extra rdreq; full_n=1 -> write proceeds next cycle.
- Stop flush: 5 words written, enable deasserted -> exactly one pktend_n pulse within 2 cycles of IDLE; with 0 words pending -> no pulse.
- Abort: rst_all_fifo pulsed during LATCH -> slwr_n never asserted for that word, words_sent=0, state IDLE, no pktend_n.
- Async reset mid-WR: reset_n low -> slwr_n=1, fd=0, rdreq=0 immediately, without waiting for a clock edge.
